capture_ctrl: RTL and testbench
===============================

# capture_ctrl

Acquisition sequencer for the ADC capture path. It runs in the `dclk` domain and consumes the 64-bit word stream (four 16-bit words, each holding two 8-bit samples) from the capture front end. On a host arm command it waits for a trigger, then writes a programmed number of optionally decimated words into a simple-dual-port sample buffer. It reports busy/done status for readout.

## Interface
Parameters:
- `ADDR_W`, 10: sample-buffer address width; depth is 2^ADDR_W 64-bit words.
- `DEC_W`, 4: decimation-ratio width.

Ports:
- `dclk` in 1: single clock for the whole block.
- `rst_n` in 1: reset, synchronous, active-low.
- `arm` in 1: one-cycle start pulse. Ignored in ARMED/CAPTURE.
- `abort` in 1: level. Forces IDLE.
- `trig_mode` in 2: 00 immediate, 01 external edge, 10 level threshold, 11 treated as 00.
- `trig_in` in 1: external trigger, already in the `dclk` domain.
- `threshold` in 8: unsigned level-trigger threshold.
- `dec` in DEC_W: store one word every `dec`+1 eligible cycles.
- `num_words` in ADDR_W+1: words to capture.
- `din` in 64: capture word stream. Bits [15:8], [31:24], [47:40], [63:56] are the rising-edge samples.
- `buf_we` out 1: buffer write enable.
- `buf_addr` out ADDR_W: buffer write address.
- `buf_wdata` out 64: buffer write data.
- `busy` out 1: high in ARMED or CAPTURE.
- `done` out 1: high in DONE.
- `words_written` out ADDR_W+1: words stored since last arm.

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
- `din` is registered every cycle into `din_q`. `trig_in` is registered twice into `trig_q` and `trig_q2`.
- On `arm` in IDLE or DONE, the block latches `trig_mode`, `threshold`, `dec`, and `num_words`, then clears `words_written` and the write pointer.
  - `num_words` = 0: go to DONE, no writes.
  - `num_words` > 2^ADDR_W: clamp to 2^ADDR_W.
  - Otherwise: go to ARMED.
- Trigger condition in ARMED:
  - Immediate mode: always true.
  - External mode: `trig_q & ~trig_q2`.
  - Level mode: any of the four rising-edge bytes of `din_q` >= `threshold`.
- Trigger fires in ARMED:
  - The trigger-cycle `din_q` is written (first word = trigger word).
  - The decimation counter loads `dec`.
  - State goes to CAPTURE.
- In CAPTURE, each cycle:
  - Counter = 0: write `din_q` and reload `dec`.
  - Otherwise: decrement the counter.
- Each write registers `buf_we`=1, `buf_addr`=pointer and `buf_wdata`=`din_q`, then increments the pointer and `words_written`.
- On the edge that registers the write bringing `words_written` to the latched count, state goes to DONE.
  - This applies from ARMED when the count is 1.
  - The pointer never wraps.
- DONE holds until `arm` or `abort`. The buffer contents and `words_written` stay valid for readout.
- `abort` overrides `arm` and the trigger in any state:
  - State goes to IDLE on the next edge.
  - `buf_we` is 0 from that edge.
  - `words_written` is retained.
- `arm` in ARMED or CAPTURE has no effect.

## Timing
- Reset values: state IDLE; all outputs 0 (`buf_we`, `buf_addr`, `buf_wdata`, `busy`, `done`, `words_written`); internal registers 0.
- Reset mid-capture: write stops at the reset edge with no partial state. The next `arm` starts clean.
- `arm` sampled at edge 0:
  - `busy`=1 after edge 0.
  - Immediate mode: first `buf_we` after edge 1, carrying `din` from cycle 0.
- Level trigger: word N in `din` produces its buffer write two edges later.
- External trigger: `trig_in` rising in cycle t stores `din`(t) two edges later. The edge detector needs `trig_in` low for at least one cycle before the rise.
- Decimation: consecutive writes are exactly `dec`+1 cycles apart.
- `done` rises on the same edge as the last `buf_we`. Capture length = 2 + (`num_words`−1)·(`dec`+1) cycles from `arm` in immediate mode.
- `busy` and `done` are never high together.

## Test plan
- Immediate capture: reset; `trig_mode`=00, `dec`=0, `num_words`=8, `din`=incrementing count, `arm` → 8 consecutive writes, addresses 0..7, first data = `din` at the arm cycle; `done`=1 with the 8th write; `words_written`=8.
- Level trigger: `threshold`=0x80; ramp with the rising-edge byte crossing 0x80 at word 37 → first write contains word 37 at addr 0; no writes before it.
- External edge with decimation: `trig_mode`=01, `dec`=3, `num_words`=4; `trig_in` rises at cycle 50 → writes at cycles 52, 56, 60, 64 of `din`(50/54/58/62); `done` at 64.
- Abort mid-capture: `num_words`=100; `abort` after 10 writes → `buf_we`=0 next edge; state IDLE; `words_written`=10. Re-arm works and starts at addr 0.
- Boundaries: `num_words`=0 → DONE with no writes. `num_words`=2^ADDR_W+5 → exactly 2^ADDR_W writes with the last addr all-ones. `arm` during CAPTURE is ignored.
- Reset: drive `rst_n`=0 during CAPTURE → all outputs 0 on that edge; state IDLE after release.

Source files
------------

// File: rtl/capture_ctrl.sv
// ---------------------------------------------------------------------------
// capture_ctrl
//
// Acquisition sequencer for the ADC capture path (dclk domain). After a host
// arm pulse it waits for a trigger (immediate, external rising edge or level
// threshold on the rising-edge samples). It then writes a programmed number
// of optionally decimated 64-bit capture words into a simple-dual-port
// sample buffer and reports busy/done status for readout.
//
// Ports:
//   dclk          - block clock
//   rst_n         - synchronous active-low reset
//   arm           - one-cycle start pulse, accepted in IDLE/DONE only
//   abort         - level, forces IDLE; overrides arm and trigger
//   trig_mode     - 00 immediate, 01 external edge, 10 level, 11 immediate
//   trig_in       - external trigger, already in dclk domain
//   threshold     - unsigned level-trigger threshold
//   dec           - store one word every dec+1 eligible cycles
//   num_words     - words to capture (clamped to buffer depth)
//   din           - capture words; bytes [15:8],[31:24],[47:40],[63:56]
//                   are the rising-edge samples
//   buf_we/buf_addr/buf_wdata - sample-buffer write port
//   busy          - ARMED or CAPTURE
//   done          - DONE
//   words_written - words stored since the last accepted arm
// ---------------------------------------------------------------------------
module capture_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DEC_W  = 4
) (
    input  logic              dclk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              abort,
    input  logic [1:0]        trig_mode,
    input  logic              trig_in,
    input  logic [7:0]        threshold,
    input  logic [DEC_W-1:0]  dec,
    input  logic [ADDR_W:0]   num_words,
    input  logic [63:0]       din,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [63:0]       buf_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]  DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]  CNT_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]  CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [DEC_W-1:0] DEC_ZERO = {DEC_W{1'b0}};
    localparam logic [DEC_W-1:0] DEC_ONE  = {{(DEC_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            state_nxt_s;
    logic [63:0]       din_q_r;
    logic              trig_q_r;
    logic              trig_q2_r;
    logic [1:0]        mode_r;
    logic [7:0]        thr_r;
    logic [DEC_W-1:0]  dec_r;
    logic [ADDR_W:0]   num_r;
    logic [DEC_W-1:0]  cnt_r;
    logic [ADDR_W:0]   num_clamp_s;
    logic              arm_ok_s;
    logic              last_s;
    logic              trig_hit_s;
    logic              wr_s;
    logic              busy_s;
    logic              done_s;

    // True when any rising-edge sample byte of the word reaches the threshold.
    function automatic logic any_rise_ge(input logic [63:0] w, input logic [7:0] t);
        any_rise_ge = (w[15:8] >= t) || (w[31:24] >= t) ||
                      (w[47:40] >= t) || (w[63:56] >= t);
    endfunction

    // Counts beyond the buffer depth are clamped so the pointer never wraps.
    assign num_clamp_s = (num_words > DEPTH) ? DEPTH : num_words;
    assign arm_ok_s    = arm && !abort && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    // The write happening this cycle is the final one of the capture.
    assign last_s      = ((words_written + CNT_ONE) == num_r);

    // Trigger condition, evaluated on the registered stream and trigger.
    always_comb begin
        trig_hit_s = 1'b1;
        case (mode_r)
            2'b01:   trig_hit_s = trig_q_r && !trig_q2_r;
            2'b10:   trig_hit_s = any_rise_ge(din_q_r, thr_r);
            default: trig_hit_s = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge dclk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; abort has priority over arm and trigger.
    always_comb begin
        state_nxt_s = state_r;
        if (abort) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state_nxt_s = (num_clamp_s == CNT_ZERO) ? ST_DONE : ST_ARMED;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_ARMED: begin
                    if (trig_hit_s) begin
                        state_nxt_s = last_s ? ST_DONE : ST_CAPTURE;
                    end else begin
                        state_nxt_s = ST_ARMED;
                    end
                end
                ST_CAPTURE: begin
                    if ((cnt_r == DEC_ZERO) && last_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_CAPTURE;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Output decode: write strobe plus status derived from the next state,
    // so the registered status lines up with the registered write.
    always_comb begin
        wr_s = 1'b0;
        if (abort) begin
            wr_s = 1'b0;
        end else if (state_r == ST_ARMED) begin
            wr_s = trig_hit_s;
        end else if (state_r == ST_CAPTURE) begin
            wr_s = (cnt_r == DEC_ZERO);
        end else begin
            wr_s = 1'b0;
        end
        busy_s = (state_nxt_s == ST_ARMED) || (state_nxt_s == ST_CAPTURE);
        done_s = (state_nxt_s == ST_DONE);
    end

    // Datapath: input staging, configuration latch, decimation, buffer writes.
    always_ff @(posedge dclk) begin
        if (!rst_n) begin
            din_q_r       <= 64'd0;
            trig_q_r      <= 1'b0;
            trig_q2_r     <= 1'b0;
            mode_r        <= 2'd0;
            thr_r         <= 8'd0;
            dec_r         <= DEC_ZERO;
            num_r         <= CNT_ZERO;
            cnt_r         <= DEC_ZERO;
            buf_we        <= 1'b0;
            buf_addr      <= {ADDR_W{1'b0}};
            buf_wdata     <= 64'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            words_written <= CNT_ZERO;
        end else begin
            din_q_r   <= din;
            trig_q_r  <= trig_in;
            trig_q2_r <= trig_q_r;
            buf_we    <= wr_s;
            busy      <= busy_s;
            done      <= done_s;
            if (arm_ok_s) begin
                mode_r        <= trig_mode;
                thr_r         <= threshold;
                dec_r         <= dec;
                num_r         <= num_clamp_s;
                words_written <= CNT_ZERO;
            end else if (wr_s) begin
                // words_written doubles as the write pointer.
                buf_addr      <= words_written[ADDR_W-1:0];
                buf_wdata     <= din_q_r;
                words_written <= words_written + CNT_ONE;
            end else begin
                words_written <= words_written;
            end
            if ((state_r == ST_ARMED) && trig_hit_s) begin
                cnt_r <= dec_r;
            end else if (state_r == ST_CAPTURE) begin
                cnt_r <= (cnt_r == DEC_ZERO) ? dec_r : (cnt_r - DEC_ONE);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_capture_ctrl
//
// Drives capture scenarios cycle by cycle, records the DUT outputs after
// every edge, then compares them with a closed-form reference: trigger cycle
// T is searched from the input history, write k lands on edge T+k*(dec+1)
// with the word sampled one cycle earlier, truncated by abort or reset.
// ---------------------------------------------------------------------------
module tb_capture_ctrl;

    localparam int ADDR_W = 10;
    localparam int DEC_W  = 4;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int MAXC   = 1100;
    localparam int BIG    = 1 << 30;

    logic              dclk = 1'b0;
    logic              rst_n;
    logic              arm;
    logic              abort;
    logic [1:0]        trig_mode;
    logic              trig_in;
    logic [7:0]        threshold;
    logic [DEC_W-1:0]  dec;
    logic [ADDR_W:0]   num_words;
    logic [63:0]       din;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [63:0]       buf_wdata;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   words_written;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0]       din_h  [MAXC];
    logic              trig_h [MAXC];
    logic              we_h   [MAXC];
    logic [ADDR_W-1:0] addr_h [MAXC];
    logic [63:0]       data_h [MAXC];
    logic              busy_h [MAXC];
    logic              done_h [MAXC];
    logic [ADDR_W:0]   ww_h   [MAXC];

    capture_ctrl #(.ADDR_W(ADDR_W), .DEC_W(DEC_W)) dut (
        .dclk(dclk), .rst_n(rst_n), .arm(arm), .abort(abort),
        .trig_mode(trig_mode), .trig_in(trig_in), .threshold(threshold),
        .dec(dec), .num_words(num_words), .din(din),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .busy(busy), .done(done), .words_written(words_written)
    );

    always #5 dclk = ~dclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge dclk);
            arm = 1'b0; abort = 1'b0; rst_n = 1'b1; trig_in = 1'b0; din = 64'd0;
        end
    endtask

    // dkind: 0 random, 1 threshold ramp, 2 count. tkind: 0 low, 1 rise at trise, 2 random.
    // ab / xarm / rc: cycle of abort / extra arm / reset pulse, -1 for none.
    task automatic run(input string name, input int mode, input int dv, input int nw,
                       input int thr, input int dkind, input int tkind, input int trise,
                       input int ab, input int xarm, input int rc, input int len);
        int n_eff, step, t, le, stop, nexp, k, e_lim;
        logic [7:0] r;
        logic cond, exp_we;
        for (int c = 0; c < len; c++) begin
            @(negedge dclk);
            r = (c + 91 > 255) ? 8'hFF : 8'(c + 91);
            case (dkind)
                1:       din_h[c] = {4{r, 8'hFF}};
                2:       din_h[c] = 64'(c);
                default: din_h[c] = {$urandom(), $urandom()};
            endcase
            case (tkind)
                1:       trig_h[c] = (c >= trise);
                2:       trig_h[c] = 1'($urandom_range(0, 1));
                default: trig_h[c] = 1'b0;
            endcase
            din = din_h[c];
            trig_in = trig_h[c];
            arm = (c == 0) || (c == xarm);
            abort = (c == ab);
            rst_n = (c != rc);
            if (c == 0) begin
                trig_mode = 2'(mode); threshold = 8'(thr);
                dec = DEC_W'(dv); num_words = (ADDR_W+1)'(nw);
            end else begin
                // Scrambled after arm: the block must use its latched copy.
                trig_mode = 2'($urandom_range(0, 3)); threshold = 8'($urandom());
                dec = DEC_W'($urandom()); num_words = (ADDR_W+1)'($urandom());
            end
            @(posedge dclk);
            #1;
            we_h[c] = buf_we; addr_h[c] = buf_addr; data_h[c] = buf_wdata;
            busy_h[c] = busy; done_h[c] = done; ww_h[c] = words_written;
        end

        n_eff = (nw > DEPTH) ? DEPTH : nw;
        step = dv + 1;
        stop = BIG;
        if (ab >= 0) stop = ab;
        if (rc >= 0 && rc < stop) stop = rc;
        t = -1;
        if (n_eff > 0) begin
            for (int c = 1; c < len && t < 0; c++) begin
                case (mode)
                    1: cond = trig_h[c-1] && !((c >= 2) ? trig_h[c-2] : 1'b0);
                    2: cond = (din_h[c-1][15:8] >= 8'(thr)) || (din_h[c-1][31:24] >= 8'(thr)) ||
                              (din_h[c-1][47:40] >= 8'(thr)) || (din_h[c-1][63:56] >= 8'(thr));
                    default: cond = 1'b1;
                endcase
                if (cond) t = c;
            end
        end
        le = (n_eff == 0) ? 0 : ((t < 0) ? BIG : t + (n_eff - 1) * step);

        for (int e = 0; e < len; e++) begin
            exp_we = (t >= 0) && (e >= t) && ((e - t) % step == 0) &&
                     ((e - t) / step < n_eff) && (e < stop);
            nexp = 0;
            if (t >= 0 && e >= t) begin
                e_lim = (e < stop) ? e : stop - 1;
                k = e_lim - t;
                nexp = (k < 0) ? 0 : k / step + 1;
                if (nexp > n_eff) nexp = n_eff;
            end
            if (rc >= 0 && e >= rc) nexp = 0;
            check($sformatf("%s.we@%0d", name, e), 64'(we_h[e]), 64'(exp_we));
            check($sformatf("%s.busy@%0d", name, e), 64'(busy_h[e]), 64'(e < le && e < stop));
            check($sformatf("%s.done@%0d", name, e), 64'(done_h[e]), 64'(e >= le && e < stop));
            check($sformatf("%s.ww@%0d", name, e), 64'(ww_h[e]), 64'(nexp));
            if (exp_we) begin
                check($sformatf("%s.addr@%0d", name, e), 64'(addr_h[e]), 64'((e - t) / step));
                check($sformatf("%s.data@%0d", name, e), data_h[e], din_h[e-1]);
            end
            if (e == rc) begin
                check($sformatf("%s.rst_addr", name), 64'(addr_h[e]), 64'd0);
                check($sformatf("%s.rst_data", name), data_h[e], 64'd0);
            end
        end

        // Return to IDLE so the next scenario starts from a known state.
        @(negedge dclk);
        arm = 1'b0; abort = 1'b1; rst_n = 1'b1; trig_in = 1'b0; din = 64'd0;
        quiet(2);
    endtask

    int m, d, n, a;

    initial begin
        rst_n = 1'b0; arm = 1'b0; abort = 1'b0; trig_mode = 2'd0; trig_in = 1'b0;
        threshold = 8'd0; dec = '0; num_words = '0; din = 64'd0;
        repeat (2) @(posedge dclk);
        #1;
        check("rst.we", 64'(buf_we), 64'd0);
        check("rst.addr", 64'(buf_addr), 64'd0);
        check("rst.data", buf_wdata, 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.ww", 64'(words_written), 64'd0);
        quiet(3);

        //   name        mode dec num           thr    dk tk trise ab  xarm rc  len
        run("immediate", 0,   0,  8,            0,     2, 0, 0,    -1, -1,  -1, 20);
        run("level",     2,   1,  8,            8'h80, 1, 0, 0,    -1, -1,  -1, 80);
        run("ext_dec",   1,   3,  4,            0,     0, 1, 50,   -1, -1,  -1, 80);
        run("abort",     0,   0,  100,          0,     2, 0, 0,    11, -1,  -1, 20);
        run("rearm",     0,   0,  5,            0,     0, 0, 0,    -1, -1,  -1, 12);
        run("zero",      0,   0,  0,            0,     0, 0, 0,    -1, -1,  -1, 6);
        run("clamp",     0,   0,  DEPTH + 5,    0,     0, 0, 0,    -1, -1,  -1, DEPTH + 10);
        run("arm_busy",  0,   2,  10,           0,     0, 0, 0,    -1, 6,   -1, 40);
        run("mode3",     3,   1,  3,            0,     0, 0, 0,    -1, -1,  -1, 12);
        run("reset",     0,   0,  50,           0,     2, 0, 0,    -1, -1,  8,  20);
        run("post_rst",  0,   1,  4,            0,     0, 0, 0,    -1, -1,  -1, 14);

        for (int i = 0; i < 12; i++) begin
            m = $urandom_range(0, 3);
            d = $urandom_range(0, 7);
            n = $urandom_range(0, 12);
            a = ($urandom_range(0, 2) == 0) ? $urandom_range(3, 60) : -1;
            run($sformatf("rnd%0d", i), m, d, n, $urandom_range(0, 255), 0, 2, 0, a, -1, -1, 120);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
